pc_sequencer: RTL and testbench

- Owns the program counter and decides the next fetch address each cycle.
- Arbitrates between sequential, branch, jump, call and return redirects, and holds an internal return-address stack.
- Drives the fetch address and a one-cycle pipeline flush to the fetch/decode stages.
- Driven by decode control signals and the ALU zero flag; replaces ad-hoc next-PC muxing in the top level.

---
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer: picks the next fetch address and owns the return-address stack.
// Redirects are registered into a one-cycle flush pulse toward fetch/decode.
module pc_sequencer #(
   parameter int                    ADDR_WIDTH  = 13,
   parameter int                    STACK_DEPTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         stall,
   input  logic                         halt,
   input  logic                         resume,
   input  logic                         control_branch,
   input  logic                         branch_cond,
   input  logic [ADDR_WIDTH-1:0]        branch_target,
   input  logic                         control_jump,
   input  logic                         control_call,
   input  logic                         control_return,
   input  logic [ADDR_WIDTH-1:0]        jump_target,
   output logic [ADDR_WIDTH-1:0]        pc,
   output logic [ADDR_WIDTH-1:0]        pc_plus_one,
   output logic                         flush,
   output logic                         halted,
   output logic [$clog2(STACK_DEPTH):0] stack_count,
   output logic                         stack_overflow,
   output logic                         stack_underflow
);

   localparam int PW = $clog2(STACK_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {RUN, HALTED} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  flush_q, flush_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  push;
   logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
   logic [PW-1:0]         pushIdx;
   logic [PW-1:0]         topIdx;

   assign pc_plus_one = pc_q + ADDR_WIDTH'(1);
   assign pushIdx     = PW'(count_q);
   assign topIdx      = PW'(count_q - CW'(1));

   // Priority: halt, stall, return, call, jump, taken branch, sequential.
   // Stack errors park the sequencer in HALTED until reset.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush_d = 1'b0;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      case (state_q)
         RUN: begin
            if (halt) begin
               state_d = HALTED;
            end else if (!stall) begin
               if (control_return) begin
                  if (count_q != '0) begin
                     pc_d    = stack_q[topIdx];
                     count_d = count_q - CW'(1);
                     flush_d = 1'b1;
                  end else begin
                     unf_d   = 1'b1;
                     state_d = HALTED;
                  end
               end else if (control_call) begin
                  if (count_q < CW'(STACK_DEPTH)) begin
                     push    = 1'b1;
                     pc_d    = jump_target;
                     count_d = count_q + CW'(1);
                     flush_d = 1'b1;
                  end else begin
                     ovf_d   = 1'b1;
                     state_d = HALTED;
                  end
               end else if (control_jump) begin
                  pc_d    = jump_target;
                  flush_d = 1'b1;
               end else if (control_branch && branch_cond) begin
                  pc_d    = branch_target;
                  flush_d = 1'b1;
               end else begin
                  pc_d = pc_plus_one;
               end
            end
         end
         HALTED: begin
            if (resume && !ovf_q && !unf_q) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Stack contents are deliberately left out of reset; occupancy alone defines validity.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= RESET_ADDR;
         flush_q <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flush_q <= flush_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         if (push) begin
            stack_q[pushIdx] <= pc_plus_one;
         end
      end
   end

   assign pc              = pc_q;
   assign flush           = flush_q;
   assign halted          = (state_q == HALTED);
   assign stack_count     = count_q;
   assign stack_overflow  = ovf_q;
   assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the main flows plus
// hand-written nested-call, LIFO and overflow sequences.
module tb_pc_sequencer;

   localparam int AW = 13;
   localparam int SD = 8;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset, stall, halt, resume;
   logic          control_branch, branch_cond, control_jump, control_call, control_return;
   logic [AW-1:0] branch_target, jump_target;
   logic [AW-1:0] pc, pc_plus_one;
   logic          flush, halted, stack_overflow, stack_underflow;
   logic [CW-1:0] stack_count;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   pc_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .RESET_ADDR('0)) dut (
      .clock(clock), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
      .control_branch(control_branch), .branch_cond(branch_cond), .branch_target(branch_target),
      .control_jump(control_jump), .control_call(control_call), .control_return(control_return),
      .jump_target(jump_target), .pc(pc), .pc_plus_one(pc_plus_one), .flush(flush),
      .halted(halted), .stack_count(stack_count), .stack_overflow(stack_overflow),
      .stack_underflow(stack_underflow)
   );

   typedef struct {
      logic          rst, stl, hlt, res, br, cond;
      logic [AW-1:0] bt;
      logic          jmp, call, ret;
      logic [AW-1:0] jt;
      logic [AW-1:0] ePc;
      logic          eFlush, eHalted;
      logic [CW-1:0] eCount;
      logic          eOvf, eUnf;
   } vec_t;

   function automatic vec_t mk(input logic rst, stl, hlt, res, br, cond, input logic [AW-1:0] bt,
                               input logic jmp, call, ret, input logic [AW-1:0] jt,
                               input logic [AW-1:0] ePc, input logic eFlush, eHalted,
                               input logic [CW-1:0] eCount, input logic eOvf, eUnf);
      vec_t v;
      v.rst = rst; v.stl = stl; v.hlt = hlt; v.res = res; v.br = br; v.cond = cond; v.bt = bt;
      v.jmp = jmp; v.call = call; v.ret = ret; v.jt = jt;
      v.ePc = ePc; v.eFlush = eFlush; v.eHalted = eHalted; v.eCount = eCount;
      v.eOvf = eOvf; v.eUnf = eUnf;
      return v;
   endfunction

   // Drive one cycle of inputs, then step past the rising edge before sampling.
   task automatic applyStimulus(input vec_t v);
      reset = v.rst; stall = v.stl; halt = v.hlt; resume = v.res;
      control_branch = v.br; branch_cond = v.cond; branch_target = v.bt;
      control_jump = v.jmp; control_call = v.call; control_return = v.ret; jump_target = v.jt;
      @(posedge clock);
      #1;
   endtask

   task automatic cmp(input string tag, input string field, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s %s: got 0x%0h expected 0x%0h", tag, field, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [AW-1:0] ePc, input logic eF, eH,
                              input logic [CW-1:0] eC, input logic eO, eU);
      cmp(tag, "pc", int'(pc), int'(ePc));
      cmp(tag, "pc_plus_one", int'(pc_plus_one), int'(AW'(ePc + AW'(1))));
      cmp(tag, "flush", int'(flush), int'(eF));
      cmp(tag, "halted", int'(halted), int'(eH));
      cmp(tag, "stack_count", int'(stack_count), int'(eC));
      cmp(tag, "stack_overflow", int'(stack_overflow), int'(eO));
      cmp(tag, "stack_underflow", int'(stack_underflow), int'(eU));
   endtask

   initial begin
      vec_t          vecs[$];
      logic [AW-1:0] model[$];
      logic [AW-1:0] curPc;
      int            depth;

      //                rst stl hlt res br cond bt       jmp call ret jt        ePc      f  h  cnt o  u
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h001, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h002, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h003, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h004, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h005, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 13'h100, 0, 0, 0, 13'h000, 13'h100, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 1, 0, 0, 13'h005, 13'h005, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 13'h100, 0, 0, 0, 13'h000, 13'h006, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 1, 0, 0, 13'h00A, 13'h00A, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 1, 0, 13'h200, 13'h200, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h201, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h202, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h203, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 1, 13'h000, 13'h00B, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 13'h000, 1, 0, 0, 13'h300, 13'h00B, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 1, 0, 0, 13'h00B, 13'h00B, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 13'h050, 0, 0, 0, 13'h000, 13'h050, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 1, 0, 0, 13'h014, 13'h014, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 13'h000, 1, 0, 0, 13'h077, 13'h014, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h014, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 1, 0, 0, 13'h077, 13'h014, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h014, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h014, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h014, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h015, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 1, 0, 0, 13'h1FFF, 13'h1FFF, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 1, 0, 0, 13'h1FFF, 13'h1FFF, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 1, 0, 13'h030, 13'h030, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 1, 13'h000, 13'h000, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 1, 13'h000, 13'h000, 0, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h000, 0, 1, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 1, 0, 0, 13'h040, 13'h040, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 13'h000, 1, 0, 0, 13'h070, 13'h000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h001, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h001, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h001, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h000, 0, 0, 0, 13'h000, 13'h002, 0, 0, 0, 0, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eFlush, vecs[i].eHalted,
                     vecs[i].eCount, vecs[i].eOvf, vecs[i].eUnf);
      end

      // Fill the stack, drain it in LIFO order, then overflow it.
      applyStimulus(mk(1, 0, 0, 0, 0, 0, '0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0));
      checkOutput("lifoReset", 13'h000, 0, 0, 0, 0, 0);
      curPc = '0;
      for (int i = 0; i < SD; i++) begin
         applyStimulus(mk(0, 0, 0, 0, 0, 0, '0, 0, 1, 0, AW'(13'h100 + i), '0, 0, 0, 0, 0, 0));
         model.push_back(AW'(curPc + AW'(1)));
         curPc = AW'(13'h100 + i);
         checkOutput($sformatf("push%0d", i), curPc, 1, 0, CW'(i + 1), 0, 0);
      end
      for (int i = 0; i < SD; i++) begin
         applyStimulus(mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 1, '0, '0, 0, 0, 0, 0, 0));
         curPc = model.pop_back();
         checkOutput($sformatf("pop%0d", i), curPc, 1, 0, CW'(SD - 1 - i), 0, 0);
      end
      depth = 0;
      for (int i = 0; i < SD + 1; i++) begin
         applyStimulus(mk(0, 0, 0, 0, 0, 0, '0, 0, 1, 0, AW'(13'h400 + i), '0, 0, 0, 0, 0, 0));
         if (depth < SD) begin
            depth++;
            curPc = AW'(13'h400 + i);
            checkOutput($sformatf("nest%0d", i), curPc, 1, 0, CW'(depth), 0, 0);
         end else begin
            checkOutput("overflow", curPc, 0, 1, CW'(SD), 1, 0);
         end
      end
      applyStimulus(mk(0, 0, 0, 1, 0, 0, '0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0));
      checkOutput("ovfResume", curPc, 0, 1, CW'(SD), 1, 0);
      applyStimulus(mk(1, 0, 0, 0, 0, 0, '0, 0, 1, 0, 13'h123, '0, 0, 0, 0, 0, 0));
      checkOutput("ovfReset", 13'h000, 0, 0, 0, 0, 0);
      applyStimulus(mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0));
      checkOutput("postReset", 13'h001, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
